reg_unit: RTL and testbench
===========================

# reg_unit

Register unit (RU) of the single-cycle RV32I core: 32 × 32-bit architectural registers x0–x31 with two combinational read ports and one synchronous write port. It sits directly downstream of the write-back data mux and consumes its 32-bit `DataWr` result. It also feeds operands RURs1/RURs2 to the ALU operand muxes and the branch unit. A third combinational debug read port gives the testbench and debug logic visibility into register state.

## Interface
- `SP_INIT`, default 32'h0000_0FFC: reset value of x2 (sp).
- `BYPASS`, default 0: 1 enables write-to-read forwarding on both operand ports; 0 returns stored contents only.
- `clk`  input  1  core clock; all state updates on the rising edge.
- `rst_n`  input  1  reset: one clock; reset is synchronous and active-low.
- `RUWr`  input  1  write enable from the control unit.
- `rs1`  input  5  read address, port 1.
- `rs2`  input  5  read address, port 2.
- `rd`  input  5  write address.
- `DataWr`  input  32  write data from the write-back mux.
- `DbgAddr`  input  5  debug read address.
- `RURs1`  output  32  contents of x[rs1].
- `RURs2`  output  32  contents of x[rs2].
- `DbgData`  output  32  contents of x[DbgAddr]; never bypassed.

## Operation
- Storage is x1–x31 as flops. x0 is not stored: any read of address 0 returns 32'h0 on every port, in every mode, at all times.
- Write: on a rising edge with rst_n=1, RUWr=1 and rd≠0, x[rd] ← DataWr. A write with rd=0 is discarded with no side effect. RUWr=0 means no state change.
- Reset: on a rising edge with rst_n=0, x1 and x3–x31 ← 0 and x2 ← SP_INIT. Reset has priority over a simultaneous write; that write is lost.
- Read ports are purely combinational from addresses and storage, with no clock involvement.
- BYPASS=1: if RUWr=1, rd≠0 and rs1==rd, then RURs1 = DataWr in the same cycle. The same rule applies to RURs2 and rs2. Bypass is suppressed while rst_n=0. Both ports may bypass simultaneously when rs1==rs2==rd.
- BYPASS=0: reads always return the pre-edge stored value. A same-cycle write becomes visible only after the edge.
- No other internal state: no counters and no pending-write buffer.

## Timing
- Write latency: 1 edge. A value presented in cycle N is readable (BYPASS=0) from cycle N+1 after the edge.
- Read latency: 0 cycles (combinational). The RURs1/RURs2 path must settle within the single-cycle critical path: decode → RU read → ALU → write-back mux.
- Post-reset outputs, after the first reset edge:
  - RURs1, RURs2 and DbgData read 32'h0 for every address except 2.
  - Address 2 reads SP_INIT.
- Before the first reset edge, contents of x1–x31 are undefined (X in simulation). x0 still reads 0.
- Reset asserted mid-program: takes effect at the next edge regardless of RUWr. Contents hold until that edge, so reads during the low-rst_n cycle still show old values (no bypass).
- A write in the same cycle as rst_n deassertion (the rst_n=1 edge) is accepted normally.
- Back-to-back writes to the same rd: the last edge wins.
- Simultaneous read and write of the same register with BYPASS=0: read returns the old value for that cycle.

## Test plan
- Reset: hold rst_n=0 for 1 edge with RUWr=1, rd=5, DataWr=32'hDEAD_BEEF → x5=0, x2=32'h0000_0FFC, all others 0, DbgData sweep over 0–31 confirms.
- Basic write/read: write x1=32'h1234_5678, then x31=32'hFFFF_FFFF on consecutive edges → next cycle rs1=1, rs2=31 give 32'h1234_5678 and 32'hFFFF_FFFF.
- x0 hard-wire: RUWr=1, rd=0, DataWr=32'hA5A5_A5A5 → RURs1 with rs1=0 reads 0 before and after the edge, in both BYPASS builds; no other register changes.
- Same-cycle read/write on x7 (old value 32'h11), DataWr=32'h22, rs1=rs2=7:
  - BYPASS=0: both ports read 32'h11 pre-edge and 32'h22 post-edge.
  - BYPASS=1: both ports read 32'h22 pre-edge.
- Write gated: RUWr=0, rd=4, DataWr=32'h99 → x4 unchanged across 3 edges.
- Mid-run reset: load x2=32'h55 and x10=32'h77, then drop rst_n for one edge while writing x10=32'h88 → afterwards x10=0 and x2=SP_INIT. A write of x10=32'h88 on the rst_n=1 edge that follows → x10=32'h88.

Source files
------------

// File: rtl/reg_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_unit_if
// Description : Read/write bus between the core datapath and the register unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_unit_if;
  logic        RUWr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] DataWr;
  logic [4:0]  DbgAddr;
  logic [31:0] RURs1;
  logic [31:0] RURs2;
  logic [31:0] DbgData;

  modport master (
    output RUWr, rs1, rs2, rd, DataWr, DbgAddr,
    input  RURs1, RURs2, DbgData
  );

  modport slave (
    input  RUWr, rs1, rs2, rd, DataWr, DbgAddr,
    output RURs1, RURs2, DbgData
  );
endinterface
`default_nettype wire

// File: rtl/reg_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_unit
// Description : RV32I register file, x0 hard-wired to zero, two operand reads,
//               one debug read, one synchronous write, optional write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_unit #(
  parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
  parameter bit          BYPASS  = 1'b0
) (
  input  wire        clk,
  input  wire        rst_n,
  reg_unit_if.slave  bus
);

  logic        w_wr_en;
  logic        w_byp1;
  logic        w_byp2;
  logic [31:0] w_file [0:31];

  // Writes to x0 are dropped here so that register never needs storage.
  assign w_wr_en = rst_n && bus.RUWr && (bus.rd != 5'd0);

  assign w_file[0] = 32'h0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_regs
      logic [31:0] r_x;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_x <= (gi == 2) ? SP_INIT : 32'h0;
        end else if (w_wr_en && (bus.rd == 5'(gi))) begin
          r_x <= bus.DataWr;
        end
      end

      assign w_file[gi] = r_x;
    end
  endgenerate

  assign w_byp1 = BYPASS && w_wr_en && (bus.rs1 == bus.rd);
  assign w_byp2 = BYPASS && w_wr_en && (bus.rs2 == bus.rd);

  always_comb begin
    bus.RURs1   = w_byp1 ? bus.DataWr : w_file[bus.rs1];
    bus.RURs2   = w_byp2 ? bus.DataWr : w_file[bus.rs2];
    bus.DbgData = w_file[bus.DbgAddr];
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_unit
// Description : Random plus directed check of reg_unit, both bypass builds,
//               against an array-based architectural register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_unit;
  localparam logic [31:0] C_SP = 32'h0000_0FFC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_unit_if ifa ();
  reg_unit_if ifb ();

  reg_unit #(.SP_INIT(C_SP), .BYPASS(1'b0)) u_nobyp (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  reg_unit #(.SP_INIT(C_SP), .BYPASS(1'b1)) u_byp   (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [0:31];
  bit          model_valid = 1'b0;

  logic        cur_rstn, cur_we;
  logic [4:0]  cur_rd;
  logic [31:0] cur_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic setin(input logic rstn, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic [31:0] data, input logic [4:0] dbg);
    rst_n = rstn; cur_rstn = rstn; cur_we = we; cur_rd = d; cur_data = data;
    ifa.RUWr = we; ifa.rs1 = a1; ifa.rs2 = a2; ifa.rd = d; ifa.DataWr = data; ifa.DbgAddr = dbg;
    ifb.RUWr = we; ifb.rs1 = a1; ifb.rs2 = a2; ifb.rd = d; ifb.DataWr = data; ifb.DbgAddr = dbg;
  endtask

  // Architectural read: x0 is zero, forwarding only when the write really happens.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && cur_rstn && cur_we && cur_rd != 5'd0 && a == cur_rd) return cur_data;
    return model[a];
  endfunction

  task automatic commit();
    @(posedge clk);
    if (!cur_rstn) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 2) ? C_SP : 32'h0;
      model_valid = 1'b1;
    end else if (cur_we && cur_rd != 5'd0) begin
      model[cur_rd] = cur_data;
    end
    #1;
  endtask

  task automatic model_check();
    if (model_valid) begin
      chk("a_rs1", ifa.RURs1,   exp_rd(ifa.rs1, 1'b0));
      chk("a_rs2", ifa.RURs2,   exp_rd(ifa.rs2, 1'b0));
      chk("a_dbg", ifa.DbgData, exp_rd(ifa.DbgAddr, 1'b0));
      chk("b_rs1", ifb.RURs1,   exp_rd(ifb.rs1, 1'b1));
      chk("b_rs2", ifb.RURs2,   exp_rd(ifb.rs2, 1'b1));
      chk("b_dbg", ifb.DbgData, exp_rd(ifb.DbgAddr, 1'b0));
    end
  endtask

  task automatic step(input logic rstn, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] d, input logic [31:0] data, input logic [4:0] dbg);
    setin(rstn, we, a1, a2, d, data, dbg);
    #2;
    model_check();
    commit();
  endtask

  task automatic peek(input logic [4:0] a1, input logic [4:0] a2);
    setin(1'b1, 1'b0, a1, a2, 5'd0, 32'h0, a1);
    #1;
  endtask

  initial begin
    // Reset with a competing write to x5; x0 must read zero even before reset.
    setin(1'b0, 1'b1, 5'd0, 5'd5, 5'd5, 32'hDEAD_BEEF, 5'd0);
    #2;
    chk("x0_prereset_a", ifa.RURs1, 32'h0);
    chk("x0_prereset_b", ifb.RURs1, 32'h0);
    commit();
    for (int i = 0; i < 32; i++) begin
      setin(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 5'(i));
      #1;
      chk("rst_dbg_a", ifa.DbgData, (i == 2) ? C_SP : 32'h0);
      chk("rst_dbg_b", ifb.DbgData, (i == 2) ? C_SP : 32'h0);
    end

    // Basic write/read
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd1,  32'h1234_5678, 5'd0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd31, 32'hFFFF_FFFF, 5'd0);
    peek(5'd1, 5'd31);
    chk("wr_x1",  ifa.RURs1, 32'h1234_5678);
    chk("wr_x31", ifa.RURs2, 32'hFFFF_FFFF);

    // x0 hard-wire in both builds
    setin(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hA5A5_A5A5, 5'd0);
    #2;
    chk("x0_pre_a", ifa.RURs1, 32'h0);
    chk("x0_pre_b", ifb.RURs1, 32'h0);
    commit();
    peek(5'd0, 5'd1);
    chk("x0_post_a", ifa.RURs1, 32'h0);
    chk("x0_post_b", ifb.RURs1, 32'h0);
    chk("x0_noside", ifa.RURs2, 32'h1234_5678);

    // Same-cycle read/write on x7
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11, 5'd0);
    setin(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'h22, 5'd7);
    #2;
    chk("rw7_a_rs1", ifa.RURs1, 32'h11);
    chk("rw7_a_rs2", ifa.RURs2, 32'h11);
    chk("rw7_b_rs1", ifb.RURs1, 32'h22);
    chk("rw7_b_rs2", ifb.RURs2, 32'h22);
    chk("rw7_b_dbg", ifb.DbgData, 32'h11);
    commit();
    peek(5'd7, 5'd7);
    chk("rw7_a_post1", ifa.RURs1, 32'h22);
    chk("rw7_a_post2", ifa.RURs2, 32'h22);

    // Write gating
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 32'h44, 5'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd4, 5'd4, 5'd4, 32'h99, 5'd4);
    peek(5'd4, 5'd4);
    chk("gate_x4_a", ifa.RURs1, 32'h44);
    chk("gate_x4_b", ifb.RURs1, 32'h44);

    // Mid-run reset beats a simultaneous write; the next write is accepted
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd2,  32'h55, 5'd0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'h77, 5'd0);
    setin(1'b0, 1'b1, 5'd10, 5'd2, 5'd10, 32'h88, 5'd10);
    #2;
    chk("mrst_hold_a", ifa.RURs1, 32'h77);
    chk("mrst_nobyp_b", ifb.RURs1, 32'h77);
    chk("mrst_sp_old", ifb.RURs2, 32'h55);
    commit();
    peek(5'd10, 5'd2);
    chk("mrst_x10", ifa.RURs1, 32'h0);
    chk("mrst_x2",  ifa.RURs2, C_SP);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'h88, 5'd0);
    peek(5'd10, 5'd2);
    chk("mrst_wr_x10", ifa.RURs1, 32'h88);

    // Random traffic; addresses biased to collide often
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a1, a2, d;
      d  = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 24) != 0), 1'($urandom), a1, a2, d, $urandom,
           5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
